// File: rtl/icache_pkg.sv
// Shared widths, boolean constants and FSM encodings for the instruction cache.
package icache_pkg;
    localparam int XLEN = 32;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MISS = 2'd1,
        ST_RESP = 2'd2
    } state_t;
endpackage

// File: rtl/icache_if.sv
// Fetch-side and refill-side signals of the instruction cache; slave is the cache view.
interface icache_if import icache_pkg::*; ();
    logic            pc_req_in;
    logic [XLEN-1:0] pc_in;
    logic            inst_valid_out;
    logic [XLEN-1:0] inst_out;
    logic            if_req_out;
    logic [XLEN-1:0] inst_addr_out;
    logic            inst_done_in;
    logic [XLEN-1:0] inst_in;

    modport slave (
        input  pc_req_in, pc_in, inst_done_in, inst_in,
        output inst_valid_out, inst_out, if_req_out, inst_addr_out
    );
    modport master (
        output pc_req_in, pc_in, inst_done_in, inst_in,
        input  inst_valid_out, inst_out, if_req_out, inst_addr_out
    );
endinterface

// File: rtl/icache_array.sv
// Direct-mapped tag/data/valid storage: combinational read, one write port, sync clear-all.
// Valid bits reset asynchronously; tag and data contents are don't-care until written.
module icache_array #(
    parameter int INDEX_BITS = 7,
    parameter int TAG_BITS   = 23,
    parameter int DATA_BITS  = 32
) (
    input  logic                  core_clk,
    input  logic                  arst_n,
    input  logic                  clr_all,
    input  logic [INDEX_BITS-1:0] rd_idx,
    output logic                  rd_vld,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic [DATA_BITS-1:0]  rd_dat,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_idx,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic [DATA_BITS-1:0]  wr_dat
);
    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]     valid_q, valid_d;
    logic [TAG_BITS-1:0]  tag_q  [LINES];
    logic [DATA_BITS-1:0] data_q [LINES];

    // A clear in the same cycle as a write wins, so the line stays invalid.
    always_comb begin
        valid_d = valid_q;
        if (clr_all) begin
            valid_d = '0;
        end else if (wr_en) begin
            valid_d[wr_idx] = 1'b1;
        end
    end

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge core_clk) begin
        if (wr_en && !clr_all) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_dat;
        end
    end

    assign rd_vld = valid_q[rd_idx];
    assign rd_tag = tag_q[rd_idx];
    assign rd_dat = data_q[rd_idx];
endmodule

// File: rtl/icache.sv
// Direct-mapped one-word-per-line instruction cache: hit answers next cycle, miss refills then answers.
// rdy_in low freezes everything; flush clears all lines and aborts a refill.
module icache import icache_pkg::*; #(
    parameter int INDEX_BITS = 7,
    parameter int TAG_BITS   = 30 - INDEX_BITS
) (
    input  logic     clk_in,
    input  logic     rst_in,
    input  logic     rdy_in,
    input  logic     flush_in,
    icache_if.slave  bus
);
    state_t          state_q, state_d;
    logic [XLEN-1:0] miss_addr_q, miss_addr_d;
    logic            if_req_q, if_req_d;
    logic [XLEN-1:0] inst_addr_q, inst_addr_d;
    logic            inst_valid_q, inst_valid_d;
    logic [XLEN-1:0] inst_q, inst_d;

    logic [XLEN-1:0]       pc_word;
    logic                  rd_vld, wr_en, clr_all, hit;
    logic [TAG_BITS-1:0]   rd_tag;
    logic [XLEN-1:0]       rd_dat;

    assign pc_word = bus.pc_in & {{(XLEN-2){1'b1}}, 2'b00};
    assign hit     = rd_vld && (rd_tag == pc_word[XLEN-1 -: TAG_BITS]);

    icache_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS),
        .DATA_BITS  (XLEN)
    ) u_array (
        .core_clk (clk_in),
        .arst_n   (rst_in),
        .clr_all  (clr_all),
        .rd_idx   (pc_word[INDEX_BITS+1:2]),
        .rd_vld   (rd_vld),
        .rd_tag   (rd_tag),
        .rd_dat   (rd_dat),
        .wr_en    (wr_en),
        .wr_idx   (miss_addr_q[INDEX_BITS+1:2]),
        .wr_tag   (miss_addr_q[XLEN-1 -: TAG_BITS]),
        .wr_dat   (bus.inst_in)
    );

    always_comb begin
        state_d      = state_q;
        miss_addr_d  = miss_addr_q;
        if_req_d     = if_req_q;
        inst_addr_d  = inst_addr_q;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        wr_en        = FALSE;
        clr_all      = FALSE;
        if (rdy_in) begin
            inst_valid_d = FALSE;
            inst_d       = '0;
            if (flush_in) begin
                clr_all     = TRUE;
                state_d     = ST_IDLE;
                if_req_d    = FALSE;
                inst_addr_d = '0;
            end else begin
                case (state_q)
                    // A request still high during the response pulse is the one just served.
                    ST_IDLE: if (bus.pc_req_in && !inst_valid_q) begin
                        if (hit) begin
                            inst_valid_d = TRUE;
                            inst_d       = rd_dat;
                        end else begin
                            state_d     = ST_MISS;
                            miss_addr_d = pc_word;
                            if_req_d    = TRUE;
                            inst_addr_d = pc_word;
                        end
                    end
                    ST_MISS: if (!bus.pc_req_in || pc_word != miss_addr_q) begin
                        state_d     = ST_IDLE;
                        if_req_d    = FALSE;
                        inst_addr_d = '0;
                    end else if (bus.inst_done_in) begin
                        wr_en        = TRUE;
                        state_d      = ST_RESP;
                        if_req_d     = FALSE;
                        inst_addr_d  = '0;
                        inst_valid_d = TRUE;
                        inst_d       = bus.inst_in;
                    end
                    ST_RESP: state_d = ST_IDLE;
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= ST_IDLE;
            miss_addr_q  <= '0;
            if_req_q     <= FALSE;
            inst_addr_q  <= '0;
            inst_valid_q <= FALSE;
            inst_q       <= '0;
        end else begin
            state_q      <= state_d;
            miss_addr_q  <= miss_addr_d;
            if_req_q     <= if_req_d;
            inst_addr_q  <= inst_addr_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
        end
    end

    assign bus.if_req_out     = if_req_q;
    assign bus.inst_addr_out  = inst_addr_q;
    assign bus.inst_valid_out = inst_valid_q;
    assign bus.inst_out       = inst_q;
endmodule

// File: tb/tb_icache.sv
// Directed scoreboard bench for icache: stimulus queues expected refills and responses,
// a negedge monitor pops and compares them whenever the cache presents one.
module tb_icache;
    logic clk = 1'b0;
    logic rst_n, rdy, flush;
    int   n_checks = 0;
    int   n_err    = 0;

    logic [31:0] exp_inst_q[$];
    logic [31:0] exp_refill_q[$];
    logic        prev_req = 1'b0;
    logic [31:0] prev_addr = '0;

    icache_if bus();

    icache #(.INDEX_BITS(7)) dut (
        .clk_in   (clk),
        .rst_in   (rst_n),
        .rdy_in   (rdy),
        .flush_in (flush),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Monitor: responses and refill requests are checked against the queues.
    always @(negedge clk) begin
        logic [31:0] e;
        if (bus.inst_valid_out) begin
            if (exp_inst_q.size() == 0) fail_now("unexpected_inst_valid");
            else begin
                e = exp_inst_q.pop_front();
                check("inst_out", bus.inst_out, e);
            end
        end else begin
            check("inst_out_idle_zero", bus.inst_out, 32'h0);
        end
        if (bus.if_req_out && !prev_req) begin
            if (exp_refill_q.size() == 0) fail_now("unexpected_refill");
            else begin
                e = exp_refill_q.pop_front();
                check("refill_addr", bus.inst_addr_out, e);
            end
        end else if (bus.if_req_out) begin
            check("refill_addr_hold", bus.inst_addr_out, prev_addr);
        end else begin
            check("refill_addr_idle_zero", bus.inst_addr_out, 32'h0);
        end
        prev_req  = bus.if_req_out;
        prev_addr = bus.inst_addr_out;
    end

    task automatic wait_if_req();
        for (int i = 0; i < 20 && !bus.if_req_out; i++) @(negedge clk);
        check("if_req_seen", bus.if_req_out, 1'b1);
    endtask

    task automatic complete(input logic [31:0] data, input int delay);
        repeat (delay) @(posedge clk);
        #1 bus.inst_done_in = 1'b1; bus.inst_in = data;
        @(posedge clk);
        #1 bus.inst_done_in = 1'b0; bus.inst_in = '0;
        @(negedge clk);
        check("resp_valid_after_done", bus.inst_valid_out, 1'b1);
        check("if_req_drop_on_done", bus.if_req_out, 1'b0);
        @(posedge clk);
        #1 bus.pc_req_in = 1'b0;
    endtask

    task automatic fetch_miss(input logic [31:0] addr, input logic [31:0] data, input int delay);
        exp_refill_q.push_back(addr);
        exp_inst_q.push_back(data);
        @(posedge clk);
        #1 bus.pc_req_in = 1'b1; bus.pc_in = addr;
        wait_if_req();
        complete(data, delay);
    endtask

    task automatic fetch_hit(input logic [31:0] addr, input logic [31:0] data);
        exp_inst_q.push_back(data);
        @(posedge clk);
        #1 bus.pc_req_in = 1'b1; bus.pc_in = addr;
        @(posedge clk);
        @(negedge clk);
        check("hit_latency", bus.inst_valid_out, 1'b1);
        @(posedge clk);
        #1 bus.pc_req_in = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; rdy = 1'b1; flush = 1'b0;
        bus.pc_req_in = 1'b0; bus.pc_in = '0;
        bus.inst_done_in = 1'b0; bus.inst_in = '0;
        #3;
        check("rst_if_req", bus.if_req_out, 1'b0);
        check("rst_inst_addr", bus.inst_addr_out, 32'h0);
        check("rst_inst_valid", bus.inst_valid_out, 1'b0);
        check("rst_inst_out", bus.inst_out, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Cold miss, then hit on the same line.
        fetch_miss(32'h0000_1000, 32'h0000_0013, 5);
        fetch_hit(32'h0000_1000, 32'h0000_0013);

        // Same index, different tag evicts; original address then misses again.
        fetch_miss(32'h0000_1200, 32'hDEAD_BEEF, 3);
        fetch_miss(32'h0000_1000, 32'h0000_0013, 2);

        // Abort: pc changes mid-miss.
        exp_refill_q.push_back(32'h0000_2000);
        exp_refill_q.push_back(32'h0000_2004);
        exp_inst_q.push_back(32'h2222_2222);
        @(posedge clk); #1 bus.pc_req_in = 1'b1; bus.pc_in = 32'h0000_2000;
        wait_if_req();
        @(posedge clk); #1 bus.pc_in = 32'h0000_2004;
        @(posedge clk);
        @(negedge clk);
        check("abort_if_req_low", bus.if_req_out, 1'b0);
        wait_if_req();
        complete(32'h2222_2222, 3);
        fetch_miss(32'h0000_2000, 32'h1111_1111, 2);

        // Back-to-back hits with request held; the request during the pulse is ignored.
        exp_inst_q.push_back(32'h1111_1111);
        exp_inst_q.push_back(32'h2222_2222);
        @(posedge clk); #1 bus.pc_req_in = 1'b1; bus.pc_in = 32'h0000_2000;
        @(posedge clk); @(negedge clk);
        check("b2b_first", bus.inst_valid_out, 1'b1);
        bus.pc_in = 32'h0000_2004;
        @(posedge clk); @(negedge clk);
        check("b2b_ignored", bus.inst_valid_out, 1'b0);
        @(posedge clk); @(negedge clk);
        check("b2b_second", bus.inst_valid_out, 1'b1);
        @(posedge clk); #1 bus.pc_req_in = 1'b0;

        // Refill completion outside a miss is ignored.
        @(posedge clk); #1 bus.inst_done_in = 1'b1; bus.inst_in = 32'hBBBB_BBBB;
        @(posedge clk); #1 bus.inst_done_in = 1'b0; bus.inst_in = '0;
        @(negedge clk);
        check("done_outside_miss", bus.inst_valid_out, 1'b0);
        fetch_hit(32'h0000_2004, 32'h2222_2222);

        // Flush coincident with refill completion.
        exp_refill_q.push_back(32'h0000_3000);
        @(posedge clk); #1 bus.pc_req_in = 1'b1; bus.pc_in = 32'h0000_3000;
        wait_if_req();
        @(posedge clk); #1 bus.inst_done_in = 1'b1; bus.inst_in = 32'hBAD0_BAD0; flush = 1'b1;
        @(posedge clk); #1 bus.inst_done_in = 1'b0; bus.inst_in = '0; flush = 1'b0; bus.pc_req_in = 1'b0;
        @(negedge clk);
        check("flush_if_req", bus.if_req_out, 1'b0);
        check("flush_inst_valid", bus.inst_valid_out, 1'b0);
        fetch_miss(32'h0000_1000, 32'h0000_0013, 1);
        fetch_miss(32'h0000_2004, 32'h2222_2222, 1);

        // Stall for three cycles mid-miss.
        exp_refill_q.push_back(32'h0000_4010);
        exp_inst_q.push_back(32'hCAFE_F00D);
        @(posedge clk); #1 bus.pc_req_in = 1'b1; bus.pc_in = 32'h0000_4010;
        wait_if_req();
        @(posedge clk); #1 rdy = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("stall_if_req", bus.if_req_out, 1'b1);
            check("stall_addr", bus.inst_addr_out, 32'h0000_4010);
            check("stall_valid", bus.inst_valid_out, 1'b0);
        end
        @(posedge clk); #1 rdy = 1'b1;
        complete(32'hCAFE_F00D, 2);
        fetch_hit(32'h0000_4010, 32'hCAFE_F00D);

        // Reset during a miss discards the refill.
        exp_refill_q.push_back(32'h0000_5000);
        @(posedge clk); #1 bus.pc_req_in = 1'b1; bus.pc_in = 32'h0000_5000;
        wait_if_req();
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_if_req", bus.if_req_out, 1'b0);
        check("rst_mid_addr", bus.inst_addr_out, 32'h0);
        @(posedge clk); #1 bus.pc_req_in = 1'b0; rst_n = 1'b1;
        fetch_miss(32'h0000_5000, 32'h55AA_55AA, 2);
        fetch_miss(32'h0000_4010, 32'hCAFE_F00D, 1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("inst_queue_drained", exp_inst_q.size(), 32'd0);
        check("refill_queue_drained", exp_refill_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 SHALL provide parameter INDEX_BITS, default 7, meaning log2 of line count (128 lines, one 32-bit word per line).
REQ-002 SHALL provide parameter TAG_BITS, default 30-INDEX_BITS, meaning stored tag width.
REQ-003 SHALL provide clk_in  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL provide rst_in  input  1  reset, asynchronous, active-low.
REQ-005 SHALL provide rdy_in  input  1  when low, all state and outputs hold.
REQ-006 SHALL provide pc_req_in  input  1  IF requests the instruction at pc_in; held until inst_valid_out.
REQ-007 SHALL provide pc_in  input  32  fetch address, word-aligned; bits [1:0] ignored.
REQ-008 SHALL provide inst_valid_out  output  1  one-cycle pulse; inst_out valid.
REQ-009 SHALL provide inst_out  output  32  fetched instruction.
REQ-010 SHALL provide if_req_out  output  1  refill request to memory controller.
REQ-011 SHALL provide inst_addr_out  output  32  refill address, {pc[31:2],2'b00}.
REQ-012 SHALL provide inst_done_in  input  1  memory controller refill complete, one-cycle pulse.
REQ-013 SHALL provide inst_in  input  32  refill word, valid with inst_done_in.
REQ-014 SHALL provide flush_in  input  1  clears all valid bits and aborts any refill.

Function
REQ-015 SHALL be direct-mapped: index = addr[INDEX_BITS+1:2], tag = addr[31:INDEX_BITS+2].
REQ-016 SHALL implement FSM states IDLE, MISS, RESP; reset state IDLE.
REQ-017 IDLE with pc_req_in: hit (valid and tag match) SHALL assert inst_valid_out with line data next cycle and stay IDLE; miss SHALL latch pc into miss_addr and go MISS.
REQ-018 Hit latency SHALL be 1 cycle; back-to-back hits SHALL sustain one instruction per 2 cycles (IF drops/re-raises pc_req_in between requests; a request seen in the cycle inst_valid_out is high SHALL be ignored).
REQ-019 MISS SHALL hold if_req_out=1 and inst_addr_out=miss_addr constant until inst_done_in.
REQ-020 On inst_done_in in MISS: write inst_in, tag, valid=1 to the line; drop if_req_out the same edge; go RESP.
REQ-021 RESP SHALL pulse inst_valid_out for one cycle with the refilled word, then return IDLE.
REQ-022 If pc_in[31:2] differs from miss_addr[31:2] or pc_req_in falls while in MISS, SHALL abort: if_req_out low for at least one cycle, no line write, return IDLE.
REQ-023 inst_done_in outside MISS SHALL be ignored.
REQ-024 flush_in SHALL take priority over every other event: clear all valid bits, deassert if_req_out and inst_valid_out, go IDLE next cycle; an inst_done_in in the same cycle SHALL NOT write.
REQ-025 inst_addr_out SHALL be 0 when if_req_out is low; inst_out SHALL be 0 when inst_valid_out is low.
REQ-026 rdy_in low SHALL freeze FSM, arrays and outputs; inst_done_in arriving while rdy_in is low is not required to be captured (memory controller also stalls).

Reset
REQ-027 Asserting rst_in SHALL immediately force state IDLE, all valid bits 0, miss_addr 0, if_req_out 0, inst_addr_out 0, inst_valid_out 0, inst_out 0.
REQ-028 Reset during MISS SHALL discard the refill; first request after release SHALL miss.
REQ-029 Data and tag arrays need no reset.

Structure
REQ-030 32-bit address/data bus widths and True/False constants SHALL come from the shared defines file; FSM state encodings SHALL live there as named constants.
REQ-031 Tag/data/valid storage SHALL be one sub-module, icache_array (one read port, one write port, plus synchronous clear-all-valid).
REQ-032 Implementation SHALL target 120-400 lines of RTL.

Verification
REQ-033 Cold miss: request 0x00001000, inst_done_in after 5 cycles with 0x00000013 -> if_req_out high until done, inst_addr_out=0x00001000, inst_valid_out pulse with 0x00000013 one cycle after done.
REQ-034 Hit: re-request 0x00001000 -> inst_valid_out next cycle with 0x00000013, if_req_out stays 0.
REQ-035 Conflict: request 0x00001200 (same index, tag differs, INDEX_BITS=7) -> miss and refill with 0xDEADBEEF; then 0x00001000 -> miss again.
REQ-036 Abort: during miss on 0x00002000 switch pc_in to 0x00002004 -> if_req_out low at least one cycle, new miss on 0x00002004, no write for 0x00002000 (later request to 0x00002000 misses).
REQ-037 Flush coincident with inst_done_in -> no line written, all lines invalid, next request to 0x00001000 misses.
REQ-038 rdy_in low for 3 cycles mid-miss -> outputs frozen; refill completes correctly after rdy_in returns.
